// File: rtl/md_sched.sv
// Multiply/divide issue scheduler: holds one op in ISSUE/RUN and times its execution.
// Optional one-entry issue queue enabled by defining MD_QUEUE_EN.
module md_sched #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  d_op,
  input  logic        e_valid,
  input  logic [3:0]  e_op,
  input  logic [31:0] e_a,
  input  logic [31:0] e_b,
  input  logic        flush,
  output logic        stall,
  output logic        md_start,
  output logic [1:0]  md_op,
  output logic [31:0] md_a,
  output logic [31:0] md_b,
  output logic        busy,
  output logic        done
);

  localparam int MAX_CYC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
  localparam int CW      = $clog2(MAX_CYC + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RUN   = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;

  logic          w_e_start_op;
  logic          w_acc;
  logic          w_d_start_op;
  logic          w_d_read_op;
  logic [1:0]    w_e_code;
  logic          w_ld;
  logic          w_sel_q;
  logic          w_q_v;
  logic [1:0]    w_iss_op;
  logic [31:0]   w_iss_a;
  logic [31:0]   w_iss_b;

  assign w_e_start_op = (e_op >= 4'd1) && (e_op <= 4'd4);
  assign w_acc        = e_valid && w_e_start_op && !flush;
  assign w_d_start_op = (d_op >= 4'd1) && (d_op <= 4'd4);
  assign w_d_read_op  = (d_op >= 4'd5) && (d_op <= 4'd8);
  assign w_e_code     = 2'(e_op - 4'd1);

  assign busy     = (r_state != S_IDLE);
  assign md_start = (r_state == S_ISSUE);
  assign done     = (r_state == S_RUN) && (r_cnt == CW'(1));

`ifdef MD_QUEUE_EN
  logic        r_q_v;
  logic [1:0]  r_q_op;
  logic [31:0] r_q_a;
  logic [31:0] r_q_b;
  logic        w_q_push;
  logic        w_q_pop;

  assign w_q_v = r_q_v;
  // In the done cycle the queue slot frees up, so a new op may only enter if the old one leaves.
  assign w_q_push = w_acc && busy && (done ? r_q_v : !r_q_v);
  assign w_q_pop  = done && r_q_v && !flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q_v  <= 1'b0;
      r_q_op <= 2'd0;
      r_q_a  <= 32'd0;
      r_q_b  <= 32'd0;
    end else if (flush) begin
      r_q_v  <= 1'b0;
    end else if (w_q_push) begin
      r_q_v  <= 1'b1;
      r_q_op <= w_e_code;
      r_q_a  <= e_a;
      r_q_b  <= e_b;
    end else if (w_q_pop) begin
      r_q_v  <= 1'b0;
    end
  end

  assign stall = (w_d_read_op && (busy || r_q_v || w_acc)) || (w_d_start_op && r_q_v);
`else
  assign w_q_v = 1'b0;
  assign stall = (w_d_read_op || w_d_start_op) && (busy || w_acc);
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ld        = 1'b0;
    w_sel_q     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_acc) begin
          w_ld        = 1'b1;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_cnt_nxt   = md_op[1] ? CW'(DIV_CYC) : CW'(MULT_CYC);
        w_state_nxt = S_RUN;
      end
      S_RUN: begin
        w_cnt_nxt = r_cnt - CW'(1);
        if (done) begin
          if (w_q_v && !flush) begin
            w_ld        = 1'b1;
            w_sel_q     = 1'b1;
            w_state_nxt = S_ISSUE;
          end else if (w_acc) begin
            w_ld        = 1'b1;
            w_state_nxt = S_ISSUE;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    w_iss_op = w_e_code;
    w_iss_a  = e_a;
    w_iss_b  = e_b;
`ifdef MD_QUEUE_EN
    if (w_sel_q) begin
      w_iss_op = r_q_op;
      w_iss_a  = r_q_a;
      w_iss_b  = r_q_b;
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Issue register doubles as the operand outputs, so they hold between issues.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      md_op <= 2'd0;
      md_a  <= 32'd0;
      md_b  <= 32'd0;
    end else if (w_ld) begin
      md_op <= w_iss_op;
      md_a  <= w_iss_a;
      md_b  <= w_iss_b;
    end
  end

endmodule

// File: tb/tb_md_sched.sv
// Self-checking bench for md_sched: timestamp-based model checked every cycle plus literal spot checks.
module tb_md_sched;
  localparam int MULT_CYC = 5;
  localparam int DIV_CYC  = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  d_op = 4'd0;
  logic        e_valid = 1'b0;
  logic [3:0]  e_op = 4'd0;
  logic [31:0] e_a = 32'd0;
  logic [31:0] e_b = 32'd0;
  logic        flush = 1'b0;
  logic        stall, md_start, busy, done;
  logic [1:0]  md_op;
  logic [31:0] md_a, md_b;

  md_sched #(.MULT_CYC(MULT_CYC), .DIV_CYC(DIV_CYC)) dut (
    .clk(clk), .reset(reset), .d_op(d_op), .e_valid(e_valid), .e_op(e_op),
    .e_a(e_a), .e_b(e_b), .flush(flush), .stall(stall), .md_start(md_start),
    .md_op(md_op), .md_a(md_a), .md_b(md_b), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
  endtask

  // Model: a job is issued at an absolute cycle and finishes a fixed number of cycles later.
  bit          m_on = 1'b0;
  int          m_t = 0;
  bit          m_job = 1'b0;
  int          m_iss = 0;
  int          m_len = 0;
  logic [1:0]  m_op = 0;
  logic [31:0] m_a = 0, m_b = 0;
  bit          m_qv = 1'b0;
  logic [1:0]  m_qop = 0;
  logic [31:0] m_qa = 0, m_qb = 0;
  logic [1:0]  h_op = 0;
  logic [31:0] h_a = 0, h_b = 0;

  function automatic int op_len(input logic [1:0] c);
    return c[1] ? DIV_CYC : MULT_CYC;
  endfunction

  always @(negedge clk) begin
    bit acc, rd, st, e_busy, e_start, e_done, e_stall, used;
    acc = e_valid && (e_op >= 1) && (e_op <= 4) && !flush;
    rd  = (d_op >= 5) && (d_op <= 8);
    st  = (d_op >= 1) && (d_op <= 4);
    used = 1'b0;
    if (reset) begin
      m_job = 1'b0; m_qv = 1'b0; h_op = 0; h_a = 0; h_b = 0;
    end
    e_busy  = m_job;
    e_start = m_job && (m_t == m_iss);
    e_done  = m_job && (m_t == m_iss + m_len);
    if (e_start) begin h_op = m_op; h_a = m_a; h_b = m_b; end
`ifdef MD_QUEUE_EN
    e_stall = (rd && (e_busy || m_qv || acc)) || (st && m_qv);
`else
    e_stall = (rd || st) && (e_busy || acc);
`endif
    if (m_on) begin
      chk("busy", busy, e_busy);
      chk("md_start", md_start, e_start);
      chk("done", done, e_done);
      chk("stall", stall, e_stall);
      chk("md_op", md_op, h_op);
      chk("md_a", md_a, h_a);
      chk("md_b", md_b, h_b);
    end
    if (!reset) begin
      if (e_done) begin
        if (m_qv && !flush) begin
          m_op = m_qop; m_a = m_qa; m_b = m_qb; m_iss = m_t + 1; m_len = op_len(m_qop); m_qv = 1'b0;
        end else if (acc) begin
          m_op = 2'(e_op - 1); m_a = e_a; m_b = e_b; m_iss = m_t + 1; m_len = op_len(m_op); used = 1'b1;
        end else begin
          m_job = 1'b0;
        end
        if (flush) m_qv = 1'b0;
      end else if (m_job) begin
        if (flush) m_qv = 1'b0;
      end else if (acc) begin
        m_job = 1'b1; m_op = 2'(e_op - 1); m_a = e_a; m_b = e_b;
        m_iss = m_t + 1; m_len = op_len(m_op); used = 1'b1;
      end
`ifdef MD_QUEUE_EN
      if (acc && !used && e_busy && !m_qv) begin
        m_qv = 1'b1; m_qop = 2'(e_op - 1); m_qa = e_a; m_qb = e_b;
      end
`endif
    end
    m_t++;
  end

  // One cycle: drive after the rising edge, return just after the falling edge.
  task automatic cyc(input logic [3:0] d, input bit ev, input logic [3:0] eo,
                     input logic [31:0] a, input logic [31:0] b, input bit fl);
    @(posedge clk); #1;
    d_op = d; e_valid = ev; e_op = eo; e_a = a; e_b = b; flush = fl;
    @(negedge clk); #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1; d_op = 0; e_valid = 0; e_op = 0; e_a = 0; e_b = 0; flush = 0;
    m_on = 1'b1;
    @(negedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk); #1;
  endtask

  int n_ev;

  initial begin
    do_reset();
    chk("rst_busy", busy, 0);
    chk("rst_md_a", md_a, 0);

    // mult 3*7
    cyc(0, 1, 1, 3, 7, 0);
    chk("s1_c0_busy", busy, 0);
    for (int c = 1; c <= 8; c++) begin
      cyc(0, 0, 0, 0, 0, 0);
      if (c == 1) begin
        chk("s1_start", md_start, 1); chk("s1_op", md_op, 0);
        chk("s1_a", md_a, 3); chk("s1_b", md_b, 7);
      end
      if (c == 6) begin chk("s1_done", done, 1); chk("s1_busy6", busy, 1); end
      if (c == 7) chk("s1_idle7", busy, 0);
    end

    // divu with mfhi waiting in D
    do_reset();
    for (int c = 0; c <= 13; c++) begin
      cyc(5, c == 0, 4, 11, 2, 0);
      if (c == 0)  chk("s2_stall0", stall, 1);
      if (c == 1)  chk("s2_op", md_op, 3);
      if (c == 11) begin chk("s2_stall11", stall, 1); chk("s2_done", done, 1); end
      if (c == 12) chk("s2_stall12", stall, 0);
    end

    // new op arriving in the done cycle issues directly
    do_reset();
    for (int c = 0; c <= 9; c++) begin
      cyc(0, (c == 0) || (c == 6), (c == 0) ? 4'd1 : 4'd2, (c == 0) ? 32'd5 : 32'd9, 32'd4, 0);
      if (c == 6) chk("s3_done", done, 1);
      if (c == 7) begin chk("s3_start", md_start, 1); chk("s3_op", md_op, 1); chk("s3_a", md_a, 9); end
    end

    // div arriving while mult runs
    do_reset();
    for (int c = 0; c <= 20; c++) begin
      cyc((c >= 3 && c <= 8) ? 4'd3 : 4'd0, (c == 0) || (c == 2), (c == 0) ? 4'd1 : 4'd3,
          (c == 0) ? 32'd1 : 32'd100, (c == 0) ? 32'd2 : 32'd7, 0);
      if (c == 6) chk("s4_stall6", stall, 1);
      if (c == 7) chk("s4_stall7", stall, 0);
`ifdef MD_QUEUE_EN
      if (c == 3) chk("s4_stall3", stall, 1);
      if (c == 7) begin chk("s4_start7", md_start, 1); chk("s4_op7", md_op, 2); chk("s4_a7", md_a, 100); end
      if (c == 17) chk("s4_done17", done, 1);
      if (c == 18) chk("s4_idle18", busy, 0);
`else
      if (c == 3) chk("s4_stall3", stall, 1);
      if (c == 7) begin chk("s4_start7", md_start, 0); chk("s4_idle7", busy, 0); chk("s4_hold_a", md_a, 1); end
`endif
    end

    // queued div flushed before it starts
    do_reset();
    n_ev = 0;
    for (int c = 0; c <= 12; c++) begin
      cyc(0, (c == 0) || (c == 2), (c == 0) ? 4'd1 : 4'd3, 32'd8, 32'd8, c == 4);
      if (md_start) n_ev++;
      if (c == 7) chk("s5_idle7", busy, 0);
    end
    chk("s5_starts", n_ev, 1);

    // mult with another mult waiting in D
    do_reset();
    for (int c = 0; c <= 8; c++) begin
      cyc((c >= 1) ? 4'd1 : 4'd0, c == 0, 1, 2, 2, 0);
`ifdef MD_QUEUE_EN
      if (c == 1) chk("s6_stall1", stall, 0);
`else
      if (c == 1) chk("s6_stall1", stall, 1);
      if (c == 6) chk("s6_stall6", stall, 1);
      if (c == 7) chk("s6_stall7", stall, 0);
`endif
    end

    // non-start classes and flush-wins
    do_reset();
    cyc(0, 1, 5, 1, 1, 0); cyc(0, 1, 8, 1, 1, 0); cyc(0, 1, 9, 1, 1, 0);
    chk("s7_nostart", busy, 0);
    cyc(0, 1, 1, 1, 1, 1);
    cyc(0, 0, 0, 0, 0, 0);
    chk("s7_flushwins", busy, 0);
    cyc(6, 1, 2, 1, 1, 0);
    chk("s7_stall_acc", stall, 1);
    cyc(9, 0, 0, 0, 0, 0);
    chk("s7_stall_d9", stall, 0);
    for (int c = 0; c < 8; c++) cyc(0, 0, 0, 0, 0, 0);

    // reset in the middle of a div
    do_reset();
    cyc(0, 1, 3, 32'h1234, 32'h5, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("s8_a1", md_a, 32'h1234);
    cyc(0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk); #1;
    chk("s8_busy", busy, 0); chk("s8_a", md_a, 0); chk("s8_op", md_op, 0); chk("s8_done", done, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk); #1;
    n_ev = 0;
    for (int c = 0; c < 15; c++) begin
      cyc(0, 0, 0, 0, 0, 0);
      if (done || md_start) n_ev++;
    end
    chk("s8_quiet", n_ev, 0);

    // mixed traffic, checked by the model
    for (int c = 0; c < 400; c++) begin
      cyc(4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0), 4'($urandom_range(0, 10)),
          $urandom, $urandom, ($urandom_range(0, 9) == 0));
    end
    for (int c = 0; c < 30; c++) cyc(0, 0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/md_sched.md
MD_SCHED -- requirements
Module: md_sched

Interface
REQ-001 SHALL have parameter MULT_CYC, default 5: execution cycles of mult/multu.
REQ-002 SHALL have parameter DIV_CYC, default 10: execution cycles of div/divu.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port d_op  input  4  D-stage md class: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo; 9-15 treated as none.
REQ-006 SHALL have port e_valid  input  1  E-stage instruction issues to the md path this cycle.
REQ-007 SHALL have port e_op  input  4  E-stage md class, same encoding as d_op.
REQ-008 SHALL have port e_a  input  32  E-stage rs operand.
REQ-009 SHALL have port e_b  input  32  E-stage rt operand.
REQ-010 SHALL have port flush  input  1  cancel the queued (not yet started) op.
REQ-011 SHALL have port stall  output  1  freeze D stage (combinational).
REQ-012 SHALL have port md_start  output  1  one-cycle start pulse to the multiply/divide unit.
REQ-013 SHALL have port md_op  output  2  0 mult, 1 multu, 2 div, 3 divu; valid with md_start.
REQ-014 SHALL have port md_a  output  32  registered operand A; valid with md_start.
REQ-015 SHALL have port md_b  output  32  registered operand B; valid with md_start.
REQ-016 SHALL have port busy  output  1  an op is issuing or executing.
REQ-017 SHALL have port done  output  1  one-cycle pulse in the last execution cycle.

Function
REQ-018 SHALL implement states IDLE, ISSUE, RUN, with a down-counter cnt wide enough for max(MULT_CYC, DIV_CYC).
REQ-019 An accepted start op is e_valid=1 with e_op in 1-4 and flush=0; e_op 5-8 or none SHALL cause no state change.
REQ-020 IDLE: an accepted start op SHALL latch op/e_a/e_b into the issue register and go to ISSUE next cycle.
REQ-021 ISSUE: md_start=1 for exactly that cycle; cnt loaded with MULT_CYC (ops 1-2) or DIV_CYC (ops 3-4); next state RUN.
REQ-022 RUN: cnt decrements each cycle; done=1 while cnt==1; after the done cycle go to ISSUE if a queued op exists, else IDLE.
REQ-023 busy SHALL equal (state != IDLE); mult accepted at cycle 0 gives md_start at 1, done at 1+MULT_CYC, IDLE at 2+MULT_CYC.
REQ-024 Accepted start op while busy SHALL be written to a one-entry queue (op, a, b) if empty.
REQ-025 Done cycle with queue full and a new accepted start op SHALL pop the queue into ISSUE and push the new op (simultaneous pop/push).
REQ-026 Done cycle with queue empty and a new accepted start op SHALL go directly to ISSUE with the new op.
REQ-027 Accepted start op while queue full and no pop that cycle SHALL be discarded (stall prevents this in correct use).
REQ-028 flush SHALL clear the queue next edge and never affect the op in ISSUE/RUN; flush with e_valid: flush wins.
REQ-029 stall=1 when d_op in 5-8 and (busy or queue valid or accepted start op this cycle).
REQ-030 stall=1 when d_op in 1-4 and queue valid (with MD_QUEUE_EN).
REQ-031 md_op/md_a/md_b SHALL hold their last value outside ISSUE.

Reset
REQ-032 reset=1 SHALL force, asynchronously, state IDLE, cnt 0, queue empty, md_start 0, md_op 0, md_a 0, md_b 0, busy 0, done 0; stall then depends only on inputs.
REQ-033 reset mid-operation SHALL abandon in-flight and queued ops; no done pulse follows.

Configuration
REQ-034 Macro MD_QUEUE_EN defined: one-entry queue per REQ-024..REQ-030.
REQ-035 MD_QUEUE_EN undefined: no queue; stall=1 when d_op in 1-8 and (busy or accepted start op this cycle); REQ-025 reduces to REQ-026; start op while busy discarded.

Verification
REQ-036 reset, e_valid mult (op 1), a=3, b=7 at cycle 0 -> md_start at 1 with md_op 0, md_a 3, md_b 7; done at 6; busy cycles 1-6.
REQ-037 divu (op 4) at cycle 0, d_op=5 held -> stall 1 cycles 0-11, 0 at cycle 12; done at 11.
REQ-038 MD_QUEUE_EN: mult at 0, div at 2 -> div queued, md_start again at 7 with md_op 2, done at 17; d_op=3 at cycle 3 stalls until 7.
REQ-039 MD_QUEUE_EN: mult at 0, div at 2, flush at 4 -> queue cleared, no second md_start, IDLE at 7.
REQ-040 reset asserted at cycle 3 of a div -> all outputs 0 immediately; no done or md_start thereafter without new request.
REQ-041 MD_QUEUE_EN undefined: mult at 0, d_op=1 at 1 -> stall cycles 1-6.
